// File: rtl/_arb4way16_pkg.sv
// rtl/_arb4way16_pkg.sv - shared state codes and requester index codes for the 4-way arbiter
package _arb4way16_pkg;

   localparam int ARB_N = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   typedef logic [0:1] arb_idx_t;

   localparam arb_idx_t IDX_A = 2'd0;
   localparam arb_idx_t IDX_B = 2'd1;
   localparam arb_idx_t IDX_C = 2'd2;
   localparam arb_idx_t IDX_D = 2'd3;

endpackage

// File: rtl/_arb4way16_rr_pick4.sv
// rtl/_arb4way16_rr_pick4.sv - round-robin winner search starting one past ptr, skipping masked requesters
module _rr_pick4
   import _arb4way16_pkg::*;
(
   input  logic [0:3] req,
   input  arb_idx_t   ptr,
   input  logic [0:3] mask,
   output logic       any,
   output arb_idx_t   idx
);

   logic [0:3] eligible;
   arb_idx_t   cand;

   assign eligible = req & ~mask;

   // ptr itself is scanned last, so the previous owner has lowest priority
   always_comb begin
      any  = 1'b0;
      idx  = ptr;
      cand = ptr;
      for (int k = 1; k <= ARB_N; k++) begin
         cand = ptr + 2'(k);
         if (!any && eligible[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/_dmux4way.sv
// rtl/_dmux4way.sv - 1-to-4 demultiplexer, routes in to the output picked by sel
module _dmux4way (
   input  logic       in,
   input  logic [0:1] sel,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d
);

   assign a = in & (sel == 2'd0);
   assign b = in & (sel == 2'd1);
   assign c = in & (sel == 2'd2);
   assign d = in & (sel == 2'd3);

endmodule

// File: rtl/_mux4way16.sv
// rtl/_mux4way16.sv - 4-way 16-bit word multiplexer, sel[0] is the MSB
module _mux4way16 (
   input  logic [0:15] a,
   input  logic [0:15] b,
   input  logic [0:15] c,
   input  logic [0:15] d,
   input  logic [0:1]  sel,
   output logic [0:15] out
);

   always_comb begin
      case (sel)
         2'd0:    out = a;
         2'd1:    out = b;
         2'd2:    out = c;
         default: out = d;
      endcase
   end

endmodule

// File: rtl/_arb4way16.sv
// rtl/_arb4way16.sv - round-robin burst arbiter sharing one 16-bit bus between four requesters
module _arb4way16
   import _arb4way16_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  logic        in_clk,
   input  logic        in_rst_n,
   input  logic [0:3]  in_req,
   input  logic [0:3]  in_last,
   input  logic [0:15] in_a,
   input  logic [0:15] in_b,
   input  logic [0:15] in_c,
   input  logic [0:15] in_d,
   input  logic        in_ready,
   output logic [0:15] out_y,
   output logic        out_valid,
   output logic [0:3]  out_gnt,
   output logic [0:1]  out_sel
);

   arb_state_t state, state_nx;
   arb_idx_t   ptr, ptr_nx;
   arb_idx_t   sel, sel_nx;
   logic [7:0] cnt, cnt_nx, cnt_inc;

   logic       busy;
   logic       xfer;
   logic       burst_end;
   logic       pick_any;
   arb_idx_t   pick_idx;
   arb_idx_t   pick_ptr;

   assign busy    = (state == ARB_BUSY);
   assign out_sel = sel;
   assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

   // On a burst end the pointer moves to the owner in the same edge, so search from sel
   assign pick_ptr = busy ? sel : ptr;

   _rr_pick4 u_pick (
      .req  (in_req),
      .ptr  (pick_ptr),
      .mask (out_gnt),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   _mux4way16 u_mux (
      .a   (in_a),
      .b   (in_b),
      .c   (in_c),
      .d   (in_d),
      .sel (sel),
      .out (out_y)
   );

   _dmux4way u_dmux (
      .in  (busy),
      .sel (sel),
      .a   (out_gnt[0]),
      .b   (out_gnt[1]),
      .c   (out_gnt[2]),
      .d   (out_gnt[3])
   );

   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         state <= ARB_IDLE;
         ptr   <= IDX_D;
         sel   <= IDX_A;
         cnt   <= 8'd0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         sel   <= sel_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      sel_nx   = sel;
      cnt_nx   = cnt;
      case (state)
         ARB_IDLE: begin
            if (pick_any) begin
               state_nx = ARB_BUSY;
               sel_nx   = pick_idx;
               cnt_nx   = 8'd0;
            end
         end
         ARB_BUSY: begin
            if (burst_end) begin
               ptr_nx = sel;
               if (pick_any) begin
                  sel_nx = pick_idx;
                  cnt_nx = 8'd0;
               end else begin
                  state_nx = ARB_IDLE;
               end
            end else if (xfer) begin
               cnt_nx = cnt_inc;
            end
         end
      endcase
   end

   always_comb begin
      out_valid = busy & in_req[sel];
      xfer      = out_valid & in_ready;
      burst_end = (xfer & in_last[sel])
                | (xfer & (MAX_BURST != 0) & (cnt_inc == 8'(MAX_BURST)))
                | (busy & ~in_req[sel]);
   end

endmodule
